// File: rtl/reg_file_if.sv
// Bus bundle between the ID stage, the WB stage and the register file.
// The master drives addresses, enables and write data; the slave returns operands and the trace.
interface reg_file_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  read_en_1;
  logic [ADDR_WIDTH-1:0] read_addr_1;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic                  read_en_2;
  logic [ADDR_WIDTH-1:0] read_addr_2;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] debug_addr;
  logic [DATA_WIDTH-1:0] debug_data;
  logic [3:0]            debug_wb_rf_wen;
  logic [ADDR_WIDTH-1:0] debug_wb_rf_wnum;
  logic [DATA_WIDTH-1:0] debug_wb_rf_wdata;

  modport master (
    output read_en_1, read_addr_1, read_en_2, read_addr_2,
           write_en, write_addr, write_data, debug_addr,
    input  read_data_1, read_data_2, debug_data,
           debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport slave (
    input  read_en_1, read_addr_1, read_en_2, read_addr_2,
           write_en, write_addr, write_data, debug_addr,
    output read_data_1, read_data_2, debug_data,
           debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/reg_file.sv
// ID-stage general-purpose register file: two bypassed read ports, one WB write port,
// an unbypassed debug read port and a one-cycle-delayed write trace for difftest.
module reg_file #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_if.slave    bus
);
  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
  logic [3:0]            r_trace_wen;
  logic [ADDR_WIDTH-1:0] r_trace_wnum;
  logic [DATA_WIDTH-1:0] r_trace_wdata;

  logic                  w_wr_commit;
  logic [DATA_WIDTH-1:0] w_read_data_1;
  logic [DATA_WIDTH-1:0] w_read_data_2;
  logic [DATA_WIDTH-1:0] w_debug_data;

  // Writes to register 0 are dropped, so entry 0 stays at its reset value forever.
  assign w_wr_commit = bus.write_en && (bus.write_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
      r_trace_wen   <= 4'h0;
      r_trace_wnum  <= '0;
      r_trace_wdata <= '0;
    end else begin
      if (w_wr_commit) begin
        r_mem[bus.write_addr] <= bus.write_data;
        r_trace_wnum          <= bus.write_addr;
        r_trace_wdata         <= bus.write_data;
      end
      r_trace_wen <= w_wr_commit ? 4'hf : 4'h0;
    end
  end

  // Enable is tested before the address so an unknown address on an idle port reads 0.
  always_comb begin
    w_read_data_1 = '0;
    if (rst || !bus.read_en_1 || (bus.read_addr_1 == '0)) begin
      w_read_data_1 = '0;
    end else if (bus.write_en && (bus.write_addr == bus.read_addr_1)) begin
      w_read_data_1 = bus.write_data;
    end else begin
      w_read_data_1 = r_mem[bus.read_addr_1];
    end
  end

  always_comb begin
    w_read_data_2 = '0;
    if (rst || !bus.read_en_2 || (bus.read_addr_2 == '0)) begin
      w_read_data_2 = '0;
    end else if (bus.write_en && (bus.write_addr == bus.read_addr_2)) begin
      w_read_data_2 = bus.write_data;
    end else begin
      w_read_data_2 = r_mem[bus.read_addr_2];
    end
  end

  always_comb begin
    w_debug_data = '0;
    if (!rst && (bus.debug_addr != '0)) begin
      w_debug_data = r_mem[bus.debug_addr];
    end
  end

  assign bus.read_data_1       = w_read_data_1;
  assign bus.read_data_2       = w_read_data_2;
  assign bus.debug_data        = w_debug_data;
  assign bus.debug_wb_rf_wen   = r_trace_wen;
  assign bus.debug_wb_rf_wnum  = r_trace_wnum;
  assign bus.debug_wb_rf_wdata = r_trace_wdata;
endmodule
